// File: rtl/lc3_wb_pkg.sv
// Shared types and condition-code constants for the LC3 writeback stage.
package lc3_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_t;

  typedef logic [2:0]  reg_idx_t;
  typedef logic [15:0] word_t;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  // Exactly one NZP bit is set; sign wins over zero.
  function automatic logic [2:0] nzp_code(input logic neg, input logic zero);
    logic [2:0] code;
    if (neg) begin
      code = PSR_N;
    end else if (zero) begin
      code = PSR_Z;
    end else begin
      code = PSR_P;
    end
    return code;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// General-purpose register file: one write port, two combinational read ports.
// Write-first forwarding is compiled in when LC3_WB_BYPASS_EN is defined.
import lc3_wb_pkg::*;

module lc3_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic [$clog2(NREG)-1:0] raddr1_i,
  input  logic [$clog2(NREG)-1:0] raddr2_i,
  output logic [DW-1:0]           rdata1_o,
  output logic [DW-1:0]           rdata2_o
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  // Next-state: only the addressed entry changes on a write.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end else begin
      mem_d[waddr_i] = mem_q[waddr_i];
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef LC3_WB_BYPASS_EN
  // Read ports forward the in-flight write data when addresses collide.
  always_comb begin
    if (we_i && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = mem_q[raddr1_i];
    end
    if (we_i && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end else begin
      rdata2_o = mem_q[raddr2_i];
    end
  end
`else
  // Read ports return stored contents only.
  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    rdata2_o = mem_q[raddr2_i];
  end
`endif

endmodule

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: source mux, NZP condition code and register file.
// Optional write-first read forwarding: define LC3_WB_BYPASS_EN.
import lc3_wb_pkg::*;

module lc3_writeback #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable_writeback,
  input  logic [1:0]              W_Control,
  input  logic [DW-1:0]           aluout,
  input  logic [DW-1:0]           memout,
  input  logic [DW-1:0]           pcout,
  input  logic [$clog2(NREG)-1:0] dr,
  input  logic [$clog2(NREG)-1:0] sr1,
  input  logic [$clog2(NREG)-1:0] sr2,
  output logic [DW-1:0]           d1,
  output logic [DW-1:0]           d2,
  output logic [2:0]              psr
);

  logic [DW-1:0] wb_data_s;
  logic [2:0]    psr_q;
  logic [2:0]    psr_d;

  // Writeback source select; the reserved code falls back to the ALU.
  always_comb begin
    case (W_Control)
      WB_ALU:  wb_data_s = aluout;
      WB_MEM:  wb_data_s = memout;
      WB_PC:   wb_data_s = pcout;
      default: wb_data_s = aluout;
    endcase
  end

  // Condition code follows the value being written.
  always_comb begin
    psr_d = psr_q;
    if (enable_writeback) begin
      psr_d = nzp_code(wb_data_s[DW-1], wb_data_s == {DW{1'b0}});
    end else begin
      psr_d = psr_q;
    end
  end

  // Condition-code register; all-zero only until the first write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      psr_q <= 3'b000;
    end else begin
      psr_q <= psr_d;
    end
  end

  assign psr = psr_q;

  lc3_regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .we_i     (enable_writeback),
    .waddr_i  (dr),
    .wdata_i  (wb_data_s),
    .raddr1_i (sr1),
    .raddr2_i (sr2),
    .rdata1_o (d1),
    .rdata2_o (d2)
  );

endmodule

// File: tb/tb_lc3_writeback.sv
// Scoreboard bench for lc3_writeback: a reference model predicts read ports and psr.
module tb_lc3_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_writeback;
  logic [1:0]  W_Control;
  logic [15:0] aluout, memout, pcout;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] d1, d2;
  logic [2:0]  psr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  psr;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_r [8];
  logic [2:0]  model_psr;

  lc3_writeback #(.DW(16), .NREG(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .W_Control        (W_Control),
    .aluout           (aluout),
    .memout           (memout),
    .pcout            (pcout),
    .dr               (dr),
    .sr1              (sr1),
    .sr2              (sr2),
    .d1               (d1),
    .d2               (d2),
    .psr              (psr)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_mux(input logic [1:0] wc, input logic [15:0] a,
                                            input logic [15:0] m, input logic [15:0] p);
    if (wc == 2'd1) return m;
    else if (wc == 2'd2) return p;
    else return a;
  endfunction

  function automatic logic [2:0] model_nzp(input logic [15:0] v);
    if (v[15]) return 3'b100;
    else if (v == 16'h0000) return 3'b010;
    else return 3'b001;
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] s, input logic en,
                                             input logic [2:0] d, input logic [15:0] wb);
`ifdef LC3_WB_BYPASS_EN
    if (en && s == d) return wb;
`endif
    return model_r[s];
  endfunction

  // Called just after a falling edge: drive, check same-cycle reads, then check after the edge.
  task automatic step(input string tag, input logic en, input logic [1:0] wc,
                      input logic [15:0] a, input logic [15:0] m, input logic [15:0] p,
                      input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    logic [15:0] wb;
    exp_t e;
    enable_writeback = en; W_Control = wc; aluout = a; memout = m; pcout = p;
    dr = d; sr1 = s1; sr2 = s2;
    wb = model_mux(wc, a, m, p);
    #1;
    check_val({tag, "_pre_d1"}, d1, model_read(s1, en, d, wb));
    check_val({tag, "_pre_d2"}, d2, model_read(s2, en, d, wb));
    if (en) begin
      model_r[d] = wb;
      model_psr  = model_nzp(wb);
    end
    sb_q.push_back('{tag, model_r[s1], model_r[s2], model_psr});
    @(posedge clock);
    #1;
    check_val({tag, "_sb_level"}, 16'(sb_q.size()), 16'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.tag, "_d1"}, d1, e.d1);
      check_val({e.tag, "_d2"}, d2, e.d2);
      check_val({e.tag, "_psr"}, {13'd0, psr}, {13'd0, e.psr});
    end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_r[i] = 16'h0000;
    model_psr = 3'b000;
    reset = 1'b1;
    enable_writeback = 1'b1; W_Control = 2'd0;
    aluout = 16'h1234; memout = 16'h0000; pcout = 16'h0000;
    dr = 3'd1; sr1 = 3'd0; sr2 = 3'd0;

    // Reset sweep, spanning a rising edge with a write request that must be dropped.
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1;
      check_val("rst_d1", d1, 16'h0000);
      check_val("rst_d2", d2, 16'h0000);
      check_val("rst_psr", {13'd0, psr}, 16'h0000);
    end
    @(negedge clock);
    reset = 1'b0;

    // Source select on successive edges.
    step("sel_alu",  1'b1, 2'd0, 16'h0005, 16'h8000, 16'h3001, 3'd3, 3'd3, 3'd1);
    step("sel_mem",  1'b1, 2'd1, 16'h0005, 16'h8000, 16'h3001, 3'd3, 3'd3, 3'd1);
    step("sel_pc",   1'b1, 2'd2, 16'h0005, 16'h8000, 16'h3001, 3'd3, 3'd3, 3'd1);
    step("sel_rsv",  1'b1, 2'd3, 16'h0005, 16'h8000, 16'h3001, 3'd3, 3'd3, 3'd1);
    check_val("sel_rsv_const", d1, 16'h0005);
    step("zero",     1'b1, 2'd1, 16'h0005, 16'h0000, 16'h3001, 3'd7, 3'd7, 3'd3);
    check_val("zero_psr_const", {13'd0, psr}, 16'h0002);
    step("hold",     1'b0, 2'd0, 16'hFFFF, 16'h8000, 16'h3001, 3'd3, 3'd3, 3'd7);

    // Same-cycle read of the destination.
    step("r2_init",  1'b1, 2'd0, 16'h1111, 16'h0000, 16'h0000, 3'd2, 3'd0, 3'd2);
    step("same_cyc", 1'b1, 2'd0, 16'h2222, 16'h0000, 16'h0000, 3'd2, 3'd2, 3'd2);
    check_val("same_cyc_next", d1, 16'h2222);

    // Fill every register with a distinct value, mixing sources and signs.
    for (int i = 0; i < 8; i++) begin
      step("fill", 1'b1, 2'(i % 3), 16'h1000 + 16'(i), 16'h8100 + 16'(i), 16'h0A00 + 16'(i),
           3'(i), 3'(i), 3'((i + 3) % 8));
    end

    // Async reset between edges: outputs clear at once, the write on the next edge is dropped.
    enable_writeback = 1'b1; W_Control = 2'd0; aluout = 16'h7777; dr = 3'd5;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sr1 = 3'(i); sr2 = 3'(i + 4);
      #1;
      check_val("arst_d1", d1, 16'h0000);
      check_val("arst_d2", d2, 16'h0000);
      check_val("arst_psr", {13'd0, psr}, 16'h0000);
    end
    @(posedge clock);
    #1;
    sr1 = 3'd5;
    #1;
    check_val("arst_drop_d1", d1, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model_r[i] = 16'h0000;
    model_psr = 3'b000;

    step("post_hold",  1'b0, 2'd0, 16'h7777, 16'h0000, 16'h0000, 3'd5, 3'd5, 3'd0);
    step("post_write", 1'b1, 2'd2, 16'h0000, 16'h0000, 16'h4ABC, 3'd5, 3'd5, 3'd5);
    step("post_read",  1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd5, 3'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
